div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter: CNT_WIDTH, default 6, iteration counter width; it SHALL hold the value DATA_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a divide using the current operand_1/operand_2 (EX-stage DIV/DIVU).
REQ-006 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-007 operand_1  input  DATA_WIDTH  dividend (ID-stage operand_1 as registered into EX).
REQ-008 operand_2  input  DATA_WIDTH  divisor (ID-stage operand_2 as registered into EX).
REQ-009 flush  input  1  pipeline flush (exception/branch cancel); aborts operation.
REQ-010 stall_req  output  1  request to freeze IF/ID/EX while divide is in progress.
REQ-011 done  output  1  one-cycle pulse: quotient/remainder valid.
REQ-012 quotient  output  DATA_WIDTH  result destined for LO.
REQ-013 remainder  output  DATA_WIDTH  result destined for HI.
REQ-014 div_zero  output  1  last completed divide had divisor 0; valid with done, held afterwards.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE: start=1 and flush=0 SHALL latch operands and is_signed, clear the counter, go to BUSY; if operand_2=0 SHALL go directly to DONE with div_zero=1.
REQ-017 BUSY: one restoring shift-subtract step per cycle on magnitudes; after DATA_WIDTH steps SHALL go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; next state IDLE, or BUSY/DONE if start=1 (back-to-back accept, same rules as REQ-016).
REQ-019 Latency: start accepted in cycle N -> done in cycle N+DATA_WIDTH+1 (N+33 at default); divisor zero -> done in N+1.
REQ-020 stall_req SHALL equal (state==IDLE and start and not flush) or state==BUSY; it SHALL be 0 in DONE, so the pipeline advances on the done cycle.
REQ-021 start in BUSY SHALL be ignored; operand changes after acceptance SHALL not affect the result.
REQ-022 Signed mode: divide magnitudes; quotient negated if operand signs differ; remainder takes sign of dividend.
REQ-023 0x8000_0000 / 0xFFFF_FFFF signed SHALL yield quotient 0x8000_0000, remainder 0 (wrap-around, no trap).
REQ-024 Divisor zero: quotient SHALL be all ones, remainder SHALL equal dividend, div_zero=1.
REQ-025 flush in any state SHALL force IDLE next cycle, suppress done, deassert stall_req combinationally, and leave quotient/remainder/div_zero unchanged; flush and start together SHALL not accept.
REQ-026 quotient/remainder/div_zero SHALL update only on entry to DONE and hold until the next completion.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counter 0, done=0, stall_req=0, quotient=0, remainder=0, div_zero=0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the operation with no done pulse after release.

Structure
REQ-029 State encoding and DATA_WIDTH-derived bus macros SHALL live in the shared bus/constants header beside the existing DATA_BUS definitions.
REQ-030 One sub-module div_step SHALL implement a single combinational restoring step (partial remainder, divisor -> next remainder, quotient bit); div_ctrl holds FSM, counter, sign fix-up.

Verification
REQ-031 DIVU 100 / 7: start at cycle 0 -> stall_req cycles 0..32, done at 33, quotient 14, remainder 2, div_zero 0.
REQ-032 DIV -7 / 2 (0xFFFF_FFF9 / 2) -> quotient 0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1).
REQ-033 DIVU 5 / 0 -> done at cycle 1, quotient 0xFFFF_FFFF, remainder 5, div_zero 1.
REQ-034 DIV 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0, no extra cycles.
REQ-035 Start 100/7, flush at cycle 10 -> IDLE at 11, no done, stall_req 0 from cycle 10, prior results held; new start 9/3 at 12 -> done at 45, quotient 3.
REQ-036 rst_n low at cycle 20 of a divide -> outputs zero immediately, no done within 40 cycles after release without new start.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared constants and state encoding for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_ctrl_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_CNT_WIDTH  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring shift-subtract step on magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  dvd_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH:0]   w_shifted;
    logic [DATA_WIDTH-1:0] w_diff;

    assign w_shifted = {rem_in, dvd_bit};
    // The true difference is always below the divisor, so the low bits suffice.
    assign w_diff    = w_shifted[DATA_WIDTH-1:0] - divisor;
    assign q_bit     = (w_shifted >= {1'b0, divisor});
    assign rem_out   = q_bit ? w_diff : w_shifted[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : Multi-cycle DIV/DIVU controller with pipeline stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int CNT_WIDTH  = C_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_zero
);

    div_state_e            r_state;
    div_state_e            w_next_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_dvd;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_dsr;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;
    logic                  r_div_zero;

    logic                  w_accept;
    logic                  w_div0;
    logic                  w_last;
    logic                  w_neg_1;
    logic                  w_neg_2;
    logic [DATA_WIDTH-1:0] w_mag_1;
    logic [DATA_WIDTH-1:0] w_mag_2;
    logic [DATA_WIDTH-1:0] w_rem_nxt;
    logic                  w_q_bit;
    logic [DATA_WIDTH-1:0] w_q_mag;
    logic [DATA_WIDTH-1:0] w_q_fix;
    logic [DATA_WIDTH-1:0] w_r_fix;

    assign w_accept = start && !flush && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_div0   = (operand_2 == '0);
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

    assign w_neg_1  = is_signed && operand_1[DATA_WIDTH-1];
    assign w_neg_2  = is_signed && operand_2[DATA_WIDTH-1];
    assign w_mag_1  = w_neg_1 ? (~operand_1 + 1'b1) : operand_1;
    assign w_mag_2  = w_neg_2 ? (~operand_2 + 1'b1) : operand_2;

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_step (
        .rem_in  (r_rem),
        .dvd_bit (r_dvd[DATA_WIDTH-1]),
        .divisor (r_dsr),
        .rem_out (w_rem_nxt),
        .q_bit   (w_q_bit)
    );

    // Dividend bits shift out the top while quotient bits shift in at the bottom.
    assign w_q_mag = {r_dvd[DATA_WIDTH-2:0], w_q_bit};
    assign w_q_fix = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_r_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        stall_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_div0 ? ST_DONE : ST_BUSY;
                end
                stall_req = start;
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
                stall_req = 1'b1;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                if (w_accept) begin
                    w_next_state = w_div0 ? ST_DONE : ST_BUSY;
                end
                done = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (flush) begin
            w_next_state = ST_IDLE;
            done         = 1'b0;
            stall_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_dsr       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_dvd   <= w_mag_1;
            r_rem   <= '0;
            r_dsr   <= w_mag_2;
            r_neg_q <= w_neg_1 ^ w_neg_2;
            r_neg_r <= w_neg_1;
            if (w_div0) begin
                r_quotient  <= '1;
                r_remainder <= operand_1;
                r_div_zero  <= 1'b1;
            end
        end else if (r_state == ST_BUSY && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_rem_nxt;
            r_dvd <= w_q_mag;
            if (w_last) begin
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
                r_div_zero  <= 1'b0;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl: vector table, random ops, corners.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [DW-1:0] operand_1;
    logic [DW-1:0] operand_2;
    logic          flush;
    logic          stall_req;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            s;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        bit            dz;
        int            lat;
    } vec_t;

    vec_t vecs[$];

    div_ctrl #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic with truncating signed division.
    task automatic model(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] q, output logic [DW-1:0] r, output bit dz);
        logic signed [DW-1:0] sa;
        logic signed [DW-1:0] sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // Entered at a negedge one cycle after acceptance; returns at the done negedge.
    task automatic wait_done(input bit poke, output int lat, output bit stall_ok);
        bit seen;
        seen     = 1'b0;
        stall_ok = 1'b1;
        lat      = 1;
        while (!seen && lat <= 80) begin
            if (done === 1'b1) begin
                seen  = 1'b1;
                start = 1'b0;
                if (stall_req !== 1'b0) stall_ok = 1'b0;
            end else begin
                if (stall_req !== 1'b1) stall_ok = 1'b0;
                if (poke) begin
                    start     = 1'($urandom_range(0, 1));
                    is_signed = 1'($urandom_range(0, 1));
                    operand_1 = $urandom;
                    operand_2 = $urandom;
                end
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        if (!seen) lat = 0;
    endtask

    task automatic run_div(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit poke,
                           output logic [DW-1:0] q, output logic [DW-1:0] r, output bit dz,
                           output int lat, output bit stall_ok);
        bit acc_stall;
        @(negedge clk);
        is_signed = s;
        operand_1 = a;
        operand_2 = b;
        flush     = 1'b0;
        start     = 1'b1;
        #1 acc_stall = stall_req;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        is_signed = ~s;
        operand_1 = $urandom;
        operand_2 = $urandom;
        wait_done(poke, lat, stall_ok);
        stall_ok = stall_ok && acc_stall;
        q  = quotient;
        r  = remainder;
        dz = div_zero;
    endtask

    initial begin
        logic [DW-1:0] q, r, eq, er, a, b, last_q, last_r;
        bit            dz, edz, st, s, last_dz;
        int            lat, sel, seen;

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        flush     = 1'b0;

        vecs = '{
            '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, DW + 1},
            '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, DW + 1},
            '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1},
            '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, DW + 1},
            '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, DW + 1},
            '{1'b0, 32'd7,          32'hFFFF_FFFF,  32'd0,          32'd7,          1'b0, DW + 1},
            '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, DW + 1},
            '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, DW + 1},
            '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1},
            '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, DW + 1},
            '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, DW + 1}
        };

        repeat (2) @(negedge clk);
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        check("reset div_zero", {31'd0, div_zero}, '0);
        check("reset done", {31'd0, done}, '0);
        check("reset stall_req", {31'd0, stall_req}, '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, q, r, dz, lat, st);
            check($sformatf("vec%0d quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d div_zero", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d stall_req", i), {31'd0, st}, 32'd1);
        end

        // Divide-by-zero results persist through idle cycles.
        run_div(1'b0, 32'd5, 32'd0, 1'b0, q, r, dz, lat, st);
        repeat (3) @(negedge clk);
        check("held div_zero", {31'd0, div_zero}, 32'd1);
        check("held quotient", quotient, 32'hFFFF_FFFF);
        check("held remainder", remainder, 32'd5);
        check("idle done", {31'd0, done}, 32'd0);

        // Random operations with start pulses injected while busy.
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = '0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF;
                4: begin a = 32'h8000_0000; b = s ? 32'hFFFF_FFFF : $urandom; end
                default: b = $urandom;
            endcase
            model(s, a, b, eq, er, edz);
            run_div(s, a, b, 1'b1, q, r, dz, lat, st);
            check($sformatf("rnd%0d quotient", i), q, eq);
            check($sformatf("rnd%0d remainder", i), r, er);
            check($sformatf("rnd%0d div_zero", i), {31'd0, dz}, {31'd0, edz});
            check($sformatf("rnd%0d latency", i), lat, (b == 0) ? 1 : DW + 1);
            check($sformatf("rnd%0d stall_req", i), {31'd0, st}, 32'd1);
            last_q  = eq;
            last_r  = er;
            last_dz = edz;
        end

        // Back-to-back: normal -> div-by-zero (DONE->DONE) -> normal (DONE->BUSY).
        @(negedge clk);
        is_signed = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd10; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat, st);
        check("b2b A quotient", quotient, 32'd100);
        check("b2b A latency", lat, DW + 1);
        operand_1 = 32'd5; operand_2 = 32'd0; start = 1'b1;
        #1 check("b2b stall in done", {31'd0, stall_req}, 32'd0);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat, st);
        check("b2b B latency", lat, 1);
        check("b2b B div_zero", {31'd0, div_zero}, 32'd1);
        operand_1 = 32'd50; operand_2 = 32'd7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat, st);
        check("b2b C latency", lat, DW + 1);
        check("b2b C quotient", quotient, 32'd7);
        check("b2b C remainder", remainder, 32'd1);
        check("b2b C div_zero", {31'd0, div_zero}, 32'd0);
        last_q = 32'd7; last_r = 32'd1; last_dz = 1'b0;

        // Flush at cycle 10 of 100/7, then 9/3 from cycle 12.
        @(negedge clk);
        is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        #1;
        check("flush stall_req", {31'd0, stall_req}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        #1;
        check("post-flush stall_req", {31'd0, stall_req}, 32'd0);
        check("post-flush done", {31'd0, done}, 32'd0);
        check("post-flush quotient held", quotient, last_q);
        check("post-flush remainder held", remainder, last_r);
        check("post-flush div_zero held", {31'd0, div_zero}, {31'd0, last_dz});
        run_div(1'b0, 32'd9, 32'd3, 1'b0, q, r, dz, lat, st);
        check("after-flush quotient", q, 32'd3);
        check("after-flush remainder", r, 32'd0);
        check("after-flush latency", lat, DW + 1);

        // Reset at cycle 20 of a divide.
        @(negedge clk);
        is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (19) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check("mid-reset quotient", quotient, '0);
        check("mid-reset remainder", remainder, '0);
        check("mid-reset div_zero", {31'd0, div_zero}, '0);
        check("mid-reset done", {31'd0, done}, '0);
        check("mid-reset stall_req", {31'd0, stall_req}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("no done after reset", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
